// File: rtl/vga_bridge.sv
// vga_bridge: brings an asynchronous VGA source (syncs of unknown polarity
// plus colour) into the clk_sys domain. Every input goes through a 2-flop
// synchroniser and one output register (3-cycle latency). Colour is width
// converted by MSB replication or truncation, and the syncs are normalised
// to active-low using a per-sync polarity detector.
//
// Optional feature: define VGA_BRIDGE_MEASURE_EN to add line-per-frame
// measurement (lines_per_frame, frame_tick, ledr showing the count).
// Without it those outputs are constant or show colour status, and no
// measurement logic exists.
//
// Handshakes: none; all ports are level signals sampled every clock.
module vga_bridge #(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 4,
  parameter int POL_LOG2 = 10
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic [IN_BITS-1:0]  r_in,
  input  logic [IN_BITS-1:0]  g_in,
  input  logic [IN_BITS-1:0]  b_in,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic [OUT_BITS-1:0] vga_r,
  output logic [OUT_BITS-1:0] vga_g,
  output logic [OUT_BITS-1:0] vga_b,
  output logic                hs_pol,
  output logic                vs_pol,
  output logic [11:0]         lines_per_frame,
  output logic                frame_tick,
  output logic [9:0]          ledr
);

  localparam int BUS_W = 2 + 3 * IN_BITS;
  localparam logic [POL_LOG2-1:0] CNT_MAX = '1;
  localparam logic [POL_LOG2-1:0] HALF    = {1'b1, {(POL_LOG2-1){1'b0}}};

  logic [BUS_W-1:0]   sync1;
  logic [BUS_W-1:0]   sync2;
  logic               hs_s;
  logic               vs_s;
  logic [IN_BITS-1:0] r_s;
  logic [IN_BITS-1:0] g_s;
  logic [IN_BITS-1:0] b_s;

  assign {hs_s, vs_s, r_s, g_s, b_s} = sync2;

  // Two-flop synchroniser for all asynchronous inputs, handled as one bus.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {hs_in, vs_in, r_in, g_in, b_in};
      sync2 <= sync1;
    end
  end

  // Polarity detection: index 0 is hs, index 1 is vs.
  logic [1:0]          sync_bit;
  logic [POL_LOG2-1:0] win_cnt   [2];
  logic [POL_LOG2-1:0] high_cnt  [2];
  logic [POL_LOG2-1:0] high_next [2];
  logic [1:0]          pol;

  assign sync_bit = {vs_s, hs_s};
  assign hs_pol   = pol[0];
  assign vs_pol   = pol[1];

  // High-sample count including the current sample; saturates instead of wrapping.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      high_next[i] = (high_cnt[i] == CNT_MAX) ? high_cnt[i]
                                              : high_cnt[i] + POL_LOG2'(sync_bit[i]);
    end
  end

  // Free-running windows; a mostly-low sync means its active level is high.
  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        win_cnt[i]  <= '0;
        high_cnt[i] <= '0;
        pol[i]      <= 1'b0;
      end else begin
        win_cnt[i] <= win_cnt[i] + POL_LOG2'(1);
        if (win_cnt[i] == CNT_MAX) begin
          pol[i]      <= (high_next[i] < HALF);
          high_cnt[i] <= '0;
        end else begin
          high_cnt[i] <= high_next[i];
        end
      end
    end
  end

  // Width conversion: output bit i takes the input bit found by walking down
  // from the MSB and wrapping, which replicates MSBs when widening and keeps
  // the top bits when narrowing.
  logic [OUT_BITS-1:0] r_conv;
  logic [OUT_BITS-1:0] g_conv;
  logic [OUT_BITS-1:0] b_conv;

  for (genvar i = 0; i < OUT_BITS; i++) begin : g_conv_bit
    localparam int SRC = IN_BITS - 1 - ((OUT_BITS - 1 - i) % IN_BITS);
    assign r_conv[i] = r_s[SRC];
    assign g_conv[i] = g_s[SRC];
    assign b_conv[i] = b_s[SRC];
  end

  // Output register: sync equal to its active level drives the output low.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_hs <= hs_s ^ pol[0];
      vga_vs <= vs_s ^ pol[1];
      vga_r  <= r_conv;
      vga_g  <= g_conv;
      vga_b  <= b_conv;
    end
  end

`ifdef VGA_BRIDGE_MEASURE_EN
  logic        hs_d;
  logic        vs_d;
  logic        hs_fall;
  logic        vs_fall;
  logic [11:0] line_cnt;

  assign hs_fall = hs_d & ~vga_hs;
  assign vs_fall = vs_d & ~vga_vs;
  assign ledr    = lines_per_frame[9:0];

  // Line counter on normalised hs falls; a vs fall closes the frame. A line
  // starting on the same cycle as the frame belongs to the new frame.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_d            <= 1'b1;
      vs_d            <= 1'b1;
      line_cnt        <= '0;
      lines_per_frame <= '0;
      frame_tick      <= 1'b0;
    end else begin
      hs_d       <= vga_hs;
      vs_d       <= vga_vs;
      frame_tick <= vs_fall;
      if (vs_fall) begin
        lines_per_frame <= line_cnt;
        line_cnt        <= hs_fall ? 12'd1 : 12'd0;
      end else if (hs_fall && (line_cnt != 12'hFFF)) begin
        line_cnt <= line_cnt + 12'd1;
      end
    end
  end
`else
  logic [3:0] led_g;
  logic [3:0] led_b;

  if (OUT_BITS >= 4) begin : g_led_top
    assign led_g = vga_g[OUT_BITS-1 -: 4];
    assign led_b = vga_b[OUT_BITS-1 -: 4];
  end else begin : g_led_pad
    assign led_g = {vga_g, {(4-OUT_BITS){1'b0}}};
    assign led_b = {vga_b, {(4-OUT_BITS){1'b0}}};
  end

  assign lines_per_frame = '0;
  assign frame_tick      = 1'b0;
  assign ledr            = {2'b00, led_g, led_b};
`endif

endmodule

// File: tb/tb_vga_bridge.sv
// tb_vga_bridge: three bridge instances (4->4, 4->6, 8->4 colour) driven
// by shared syncs, checked every cycle against a behavioural model, plus
// literal expectations for reset, colour steps, polarity and line counts.
module tb_vga_bridge;

  localparam int POL         = 6;
  localparam int WIN         = 1 << POL;
  localparam int LINE_CLKS   = 8;
  localparam int FRAME_LINES = 525;
  localparam int FRAME       = LINE_CLKS * FRAME_LINES;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       reset;
  logic       hs_in;
  logic       vs_in;
  logic [3:0] c4_r, c4_g, c4_b;
  logic [7:0] c8_r, c8_g, c8_b;

  logic       a_hs, a_vs, a_hp, a_vp, a_tick;
  logic [3:0] a_r, a_g, a_b;
  logic [11:0] a_lpf;
  logic [9:0] a_ledr;
  logic       w_hs, w_vs, w_hp, w_vp, w_tick;
  logic [5:0] w_r, w_g, w_b;
  logic [11:0] w_lpf;
  logic [9:0] w_ledr;
  logic       n_hs, n_vs, n_hp, n_vp, n_tick;
  logic [3:0] n_r, n_g, n_b;
  logic [11:0] n_lpf;
  logic [9:0] n_ledr;

  vga_bridge #(.IN_BITS(4), .OUT_BITS(4), .POL_LOG2(POL)) dut_a (
    .clk_sys(clk_sys), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(c4_r), .g_in(c4_g), .b_in(c4_b),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .hs_pol(a_hp), .vs_pol(a_vp), .lines_per_frame(a_lpf),
    .frame_tick(a_tick), .ledr(a_ledr));

  vga_bridge #(.IN_BITS(4), .OUT_BITS(6), .POL_LOG2(POL)) dut_w (
    .clk_sys(clk_sys), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(c4_r), .g_in(c4_g), .b_in(c4_b),
    .vga_hs(w_hs), .vga_vs(w_vs), .vga_r(w_r), .vga_g(w_g), .vga_b(w_b),
    .hs_pol(w_hp), .vs_pol(w_vp), .lines_per_frame(w_lpf),
    .frame_tick(w_tick), .ledr(w_ledr));

  vga_bridge #(.IN_BITS(8), .OUT_BITS(4), .POL_LOG2(POL)) dut_n (
    .clk_sys(clk_sys), .reset(reset), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(c8_r), .g_in(c8_g), .b_in(c8_b),
    .vga_hs(n_hs), .vga_vs(n_vs), .vga_r(n_r), .vga_g(n_g), .vga_b(n_b),
    .hs_pol(n_hp), .vs_pol(n_vp), .lines_per_frame(n_lpf),
    .frame_tick(n_tick), .ledr(n_ledr));

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r4, g4, b4;
    logic [7:0] r8, g8, b8;
  } samp_t;

  samp_t hist[$];
  samp_t cur, old;
  bit    model_ok = 1'b0;
  int    win_pos, high_h, high_v;
  bit    pol_h, pol_v;
  bit    out_hs = 1'b1, out_vs = 1'b1, prev_hs = 1'b1, prev_vs = 1'b1;
  bit    new_hs, new_vs, hs_fall, vs_fall;
  int    line_cnt, lpf;
  bit    tick;
  logic [3:0] e_r, e_g, e_b, en_r, en_g, en_b;
  logic [5:0] ew_r, ew_g, ew_b;

  // Outputs after each clock edge reflect the inputs sampled two edges
  // earlier; polarity is the majority rule over each window since reset.
  initial begin : model
    forever begin
      @(posedge clk_sys);
      if (reset) begin
        model_ok = 1'b1;
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        win_pos = 0; high_h = 0; high_v = 0; pol_h = 1'b0; pol_v = 1'b0;
        out_hs = 1'b1; out_vs = 1'b1; prev_hs = 1'b1; prev_vs = 1'b1;
        line_cnt = 0; lpf = 0; tick = 1'b0;
        e_r = '0; e_g = '0; e_b = '0; ew_r = '0; ew_g = '0; ew_b = '0;
        en_r = '0; en_g = '0; en_b = '0;
      end else if (model_ok) begin
        cur = {hs_in, vs_in, c4_r, c4_g, c4_b, c8_r, c8_g, c8_b};
        hist.push_front(cur);
        old = hist[2];
        void'(hist.pop_back());
        // output is low exactly when the sync sits at its active level
        new_hs = !(old.hs == pol_h);
        new_vs = !(old.vs == pol_v);
        // measurement looks at falls of the already-normalised outputs
        hs_fall = prev_hs && !out_hs;
        vs_fall = prev_vs && !out_vs;
        tick = vs_fall;
        if (vs_fall) begin
          lpf = line_cnt;
          line_cnt = hs_fall ? 1 : 0;
        end else if (hs_fall && line_cnt < 4095) begin
          line_cnt++;
        end
        prev_hs = out_hs; out_hs = new_hs;
        prev_vs = out_vs; out_vs = new_vs;
        high_h += int'(old.hs);
        high_v += int'(old.vs);
        win_pos++;
        if (win_pos == WIN) begin
          pol_h = (high_h < WIN / 2);
          pol_v = (high_v < WIN / 2);
          high_h = 0; high_v = 0; win_pos = 0;
        end
        e_r = old.r4; e_g = old.g4; e_b = old.b4;
        ew_r = {old.r4, old.r4[3:2]};
        ew_g = {old.g4, old.g4[3:2]};
        ew_b = {old.b4, old.b4[3:2]};
        en_r = old.r8[7:4]; en_g = old.g8[7:4]; en_b = old.b8[7:4];
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [11:0] x_lpf;
  logic        x_tick;
  logic [9:0]  xa_ledr, xw_ledr, xn_ledr;

  always @(negedge clk_sys) begin
    if (model_ok) begin
`ifdef VGA_BRIDGE_MEASURE_EN
      x_lpf = 12'(lpf); x_tick = tick;
      xa_ledr = x_lpf[9:0]; xw_ledr = x_lpf[9:0]; xn_ledr = x_lpf[9:0];
`else
      x_lpf = '0; x_tick = 1'b0;
      xa_ledr = {2'b00, e_g, e_b};
      xw_ledr = {2'b00, ew_g[5:2], ew_b[5:2]};
      xn_ledr = {2'b00, en_g, en_b};
`endif
      check("a_hs", a_hs, out_hs);  check("a_vs", a_vs, out_vs);
      check("a_hpol", a_hp, pol_h); check("a_vpol", a_vp, pol_v);
      check("a_r", a_r, e_r); check("a_g", a_g, e_g); check("a_b", a_b, e_b);
      check("a_lpf", a_lpf, x_lpf); check("a_tick", a_tick, x_tick);
      check("a_ledr", a_ledr, xa_ledr);
      check("w_hs", w_hs, out_hs);  check("w_vs", w_vs, out_vs);
      check("w_hpol", w_hp, pol_h); check("w_vpol", w_vp, pol_v);
      check("w_r", w_r, ew_r); check("w_g", w_g, ew_g); check("w_b", w_b, ew_b);
      check("w_lpf", w_lpf, x_lpf); check("w_tick", w_tick, x_tick);
      check("w_ledr", w_ledr, xw_ledr);
      check("n_hs", n_hs, out_hs);  check("n_vs", n_vs, out_vs);
      check("n_hpol", n_hp, pol_h); check("n_vpol", n_vp, pol_v);
      check("n_r", n_r, en_r); check("n_g", n_g, en_g); check("n_b", n_b, en_b);
      check("n_lpf", n_lpf, x_lpf); check("n_tick", n_tick, x_tick);
      check("n_ledr", n_ledr, xn_ledr);
    end
  end

  // ---------------- driver tasks ----------------
  int pix = 0;
  int line = 0;
  int tick_seen = 0;

  task automatic rand_colour();
    c4_r = 4'($urandom_range(0, 15)); c4_g = 4'($urandom_range(0, 15));
    c4_b = 4'($urandom_range(0, 15));
    c8_r = 8'($urandom_range(0, 255)); c8_g = 8'($urandom_range(0, 255));
    c8_b = 8'($urandom_range(0, 255));
  endtask

  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      reset = ($urandom_range(0, 99) == 0);
      hs_in = 1'($urandom_range(0, 1));
      vs_in = 1'($urandom_range(0, 1));
      rand_colour();
    end
  endtask

  // Video timing: 8-clock lines, hs high on the first clock of each line,
  // vs high for the whole first line of each 525-line frame.
  task automatic video_cycles(input int n, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      if (a_tick === 1'b1) tick_seen++;
      reset = (i == rst_at);
      hs_in = (pix == 0);
      vs_in = (line == 0);
      rand_colour();
      pix++;
      if (pix == LINE_CLKS) begin
        pix = 0;
        line++;
        if (line == FRAME_LINES) line = 0;
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  int lows;

  initial begin
    reset = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    c4_r = '0; c4_g = '0; c4_b = '0; c8_r = '0; c8_g = '0; c8_b = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_vga_hs", a_hs, 1);   check("rst_vga_vs", a_vs, 1);
    check("rst_vga_r", a_r, 0);     check("rst_hs_pol", a_hp, 0);
    check("rst_lpf", a_lpf, 0);     check("rst_ledr", a_ledr, 0);

    // colour step: visible three clocks later
    @(negedge clk_sys);
    reset = 1'b0;
    c4_r = 4'h5; c4_g = 4'h9; c4_b = 4'hC;
    c8_r = 8'h7F; c8_g = 8'h80; c8_b = 8'h01;
    repeat (3) @(negedge clk_sys);
    check("step_r", a_r, 4'h5); check("step_g", a_g, 4'h9); check("step_b", a_b, 4'hC);
    check("narrow_r", n_r, 4'h7);
`ifndef VGA_BRIDGE_MEASURE_EN
    check("step_ledr", a_ledr, 10'h09C);
`endif
    c4_r = 4'hA;
    repeat (3) @(negedge clk_sys);
    check("wide_r", w_r, 6'h2A);

    drive_random(600);

    // polarity: hs high 4 of every 32 clocks, fresh window after reset
    @(negedge clk_sys);
    reset = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    for (int i = 0; i < WIN + 32; i++) begin
      @(negedge clk_sys);
      if (i == WIN - 2) check("pol_before_window", a_hp, 0);
      if (i == WIN - 1) check("pol_at_window", a_hp, 1);
      hs_in = ((i % 32) < 4);
      rand_colour();
    end
    lows = 0;
    for (int i = WIN + 32; i < WIN + 64; i++) begin
      @(negedge clk_sys);
      if (a_hs === 1'b0) lows++;
      hs_in = ((i % 32) < 4);
      rand_colour();
    end
    check("hs_low_clocks", lows, 4);

    // frames
    @(negedge clk_sys);
    reset = 1'b1;
    pix = 0; line = 0;
    video_cycles(2 * FRAME + 20, -1);
    tick_seen = 0;
    video_cycles(FRAME, -1);
`ifdef VGA_BRIDGE_MEASURE_EN
    check("frame_ticks", tick_seen, 1);
    check("lines_525", a_lpf, 525);
    check("ledr_20d", a_ledr, 10'h20D);
`endif

    // reset mid-frame, then the following full frame
    video_cycles(800, -1);
    video_cycles(1, 0);
    video_cycles(1, -1);
    check("midrst_lpf", a_lpf, 0);
    check("midrst_tick", a_tick, 0);
    video_cycles(2 * FRAME, -1);
`ifdef VGA_BRIDGE_MEASURE_EN
    check("after_rst_525", a_lpf, 525);
`endif

    @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
